// File: rtl/ahb_apb_pkg.sv
// Encodings shared by the AHB-to-APB bridge and its strobe generator.
package ahb_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WLAT   = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR1   = 3'd5,
    ST_ERR2   = 3'd6
  } state_t;

endpackage

// File: rtl/apb_strb_gen.sv
// Byte-lane strobes from transfer size and low address bits; zero for reads.
module apb_strb_gen
  import ahb_apb_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lo,
  input  logic       write,
  output logic [3:0] strb
);

  always_comb begin
    strb = 4'b0000;
    if (write) begin
      case (hsize)
        HSIZE_BYTE: strb = 4'b0001 << addr_lo;
        HSIZE_HALF: strb = addr_lo[1] ? 4'b1100 : 4'b0011;
        HSIZE_WORD: strb = 4'b1111;
        default:    strb = 4'b0000;
      endcase
    end
  end

endmodule

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave to APB4 master bridge: one APB setup/access per single AHB
// transfer, stalling the AHB side with hreadyout until the slave completes.
module ahb2apb_bridge
  import ahb_apb_pkg::*;
#(
  parameter int NSLV    = 4,
  parameter int SLV_LSB = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hsel,
  input  logic [31:0]          haddr,
  input  logic [1:0]           htrans,
  input  logic                 hwrite,
  input  logic [2:0]           hsize,
  input  logic [3:0]           hprot,
  input  logic [31:0]          hwdata,
  input  logic                 hready,
  output logic                 hreadyout,
  output logic [31:0]          hrdata,
  output logic                 hresp,
  output logic [31:0]          paddr,
  output logic [2:0]           pprot,
  output logic [NSLV-1:0]      psel,
  output logic                 penable,
  output logic                 pwrite,
  output logic [31:0]          pwdata,
  output logic [3:0]           pstrb,
  input  logic [NSLV*32-1:0]   prdata,
  input  logic [NSLV-1:0]      pready,
  input  logic [NSLV-1:0]      pslverr
);

  localparam int IDX_W = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam logic [IDX_W:0] NSLV_L = (IDX_W + 1)'(NSLV);

  state_t           state, next;
  logic [IDX_W-1:0] idx, idx_in;
  logic             accept, illegal, apb_phase;
  logic [3:0]       strb_in;
  logic [31:0]      prdata_sel;
  logic             pready_sel, pslverr_sel;
  logic             unused_hprot;

  assign unused_hprot = ^hprot[3:2];

  // A single-slave build has no index field, so every access targets slave 0.
  assign idx_in  = (NSLV > 1) ? haddr[SLV_LSB +: IDX_W] : '0;
  assign accept  = hsel && (htrans == HTRANS_NONSEQ) && hready &&
                   ((state == ST_IDLE) || (state == ST_DONE));
  assign illegal = ({1'b0, idx_in} >= NSLV_L) || (hsize > HSIZE_WORD);

  apb_strb_gen u_strb (
    .hsize   (hsize),
    .addr_lo (haddr[1:0]),
    .write   (hwrite),
    .strb    (strb_in)
  );

  assign apb_phase = (state == ST_SETUP) || (state == ST_ACCESS);
  assign penable   = (state == ST_ACCESS);
  assign hreadyout = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR2);
  assign hresp     = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

  always_comb begin
    prdata_sel  = '0;
    pready_sel  = 1'b0;
    pslverr_sel = 1'b0;
    psel        = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (idx == IDX_W'(i)) begin
        prdata_sel  = prdata[32*i +: 32];
        pready_sel  = pready[i];
        pslverr_sel = pslverr[i];
        psel[i]     = apb_phase;
      end
    end
  end

  always_comb begin
    next = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (!accept)      next = ST_IDLE;
        else if (illegal) next = ST_ERR1;
        else if (hwrite)  next = ST_WLAT;
        else              next = ST_SETUP;
      end
      ST_WLAT:   next = ST_SETUP;
      ST_SETUP:  next = ST_ACCESS;
      ST_ACCESS: if (pready_sel) next = pslverr_sel ? ST_ERR1 : ST_DONE;
      ST_ERR1:   next = ST_ERR2;
      ST_ERR2:   next = ST_IDLE;
      default:   next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next;
  end

  // Address phase is latched on accept; hwdata arrives one cycle later in WLAT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      paddr  <= '0;
      pwrite <= 1'b0;
      pprot  <= '0;
      pstrb  <= '0;
      pwdata <= '0;
      hrdata <= '0;
      idx    <= '0;
    end else begin
      if (accept) begin
        paddr  <= haddr;
        pwrite <= hwrite;
        pprot  <= {~hprot[0], 1'b0, hprot[1]};
        pstrb  <= strb_in;
        idx    <= idx_in;
        if (illegal) hrdata <= '0;
      end
      if (state == ST_WLAT) pwdata <= hwdata;
      if ((state == ST_ACCESS) && pready_sel)
        hrdata <= (pwrite || pslverr_sel) ? 32'h0 : prdata_sel;
    end
  end

endmodule
